// File: rtl/register_file_pkg.sv
// Shared definitions for the register file with issue scoreboard:
// default parameter values and the clear-sweep FSM state encoding.
package register_file_pkg;

  localparam int DATA_LENGTH_DEF = 32;
  localparam int ADDR_LENGTH_DEF = 5;
  localparam int BYPASS_DEF      = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/register_file_sb_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, set on issue,
// cleared on write-back, with the two read-port lookups.
module rf_scoreboard
  import register_file_pkg::*;
#(
  parameter int ADDR_LENGTH = ADDR_LENGTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_all,
  input  logic                   set_en,
  input  logic [ADDR_LENGTH-1:0] set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_LENGTH-1:0] clr_addr,
  input  logic                   lookup_en,
  input  logic                   byp_en,
  input  logic [ADDR_LENGTH-1:0] byp_addr,
  input  logic [ADDR_LENGTH-1:0] a1,
  input  logic [ADDR_LENGTH-1:0] a2,
  output logic                   busy1,
  output logic                   busy2
);

  localparam int REGS_QTY = 2 ** ADDR_LENGTH;

  logic [REGS_QTY-1:0] busy_q;
  logic [REGS_QTY-1:0] busy_d;

  // The set is applied after the clear so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    if (clear_all) busy_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (lookup_en) begin
      busy1 = (a1 != '0) && !(byp_en && (byp_addr == a1)) && busy_q[a1];
      busy2 = (a2 != '0) && !(byp_en && (byp_addr == a2)) && busy_q[a2];
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with write-to-read bypass, an issue
// scoreboard and a one-register-per-cycle clear sweep.
module register_file_sb
  import register_file_pkg::*;
#(
  parameter int DATA_LENGTH = DATA_LENGTH_DEF,
  parameter int ADDR_LENGTH = ADDR_LENGTH_DEF,
  parameter int BYPASS      = BYPASS_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_LENGTH-1:0] a1,
  input  logic [ADDR_LENGTH-1:0] a2,
  output logic [DATA_LENGTH-1:0] rd1,
  output logic [DATA_LENGTH-1:0] rd2,
  input  logic [ADDR_LENGTH-1:0] a3,
  input  logic [DATA_LENGTH-1:0] wd3,
  input  logic                   we3,
  input  logic                   iss_valid,
  input  logic [ADDR_LENGTH-1:0] iss_addr,
  output logic                   busy1,
  output logic                   busy2,
  output logic                   stall,
  input  logic                   clr,
  output logic                   ready,
  output rf_state_e              dbg_state
);

  localparam int REGS_QTY = 2 ** ADDR_LENGTH;
  localparam logic [ADDR_LENGTH-1:0] LAST_ADDR = ADDR_LENGTH'(REGS_QTY - 1);

  rf_state_e                state_q, state_d;
  logic [ADDR_LENGTH-1:0]   cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0]   regs_q [REGS_QTY];
  logic [DATA_LENGTH-1:0]   regs_d [REGS_QTY];

  logic                     idle;
  logic                     wr_en;
  logic [ADDR_LENGTH-1:0]   wr_addr;
  logic [DATA_LENGTH-1:0]   wr_data;
  logic                     sb_clear_all;
  logic                     sb_set_en;
  logic                     sb_clr_en;
  logic                     byp_en;

  assign idle = (state_q == ST_IDLE);

  // A clr request in IDLE swallows any same-cycle write or issue.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_en        = 1'b0;
    wr_addr      = a3;
    wr_data      = wd3;
    sb_clear_all = 1'b0;
    sb_set_en    = 1'b0;
    sb_clr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d      = ST_CLEAR;
          cnt_d        = ADDR_LENGTH'(1);
          sb_clear_all = 1'b1;
        end else begin
          wr_en     = we3 && (a3 != '0);
          sb_clr_en = we3;
          sb_set_en = iss_valid && (iss_addr != '0);
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + ADDR_LENGTH'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
    end
  end

  // Forwarding only applies to a live IDLE write; the sweep never bypasses.
  assign byp_en = (BYPASS != 0) && idle && we3;

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != '0) rd1 = (byp_en && (a3 == a1)) ? wd3 : regs_q[a1];
    if (a2 != '0) rd2 = (byp_en && (a3 == a2)) ? wd3 : regs_q[a2];
  end

  rf_scoreboard #(
    .ADDR_LENGTH(ADDR_LENGTH)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst),
    .clear_all(sb_clear_all),
    .set_en   (sb_set_en),
    .set_addr (iss_addr),
    .clr_en   (sb_clr_en),
    .clr_addr (a3),
    .lookup_en(idle),
    .byp_en   (byp_en),
    .byp_addr (a3),
    .a1       (a1),
    .a2       (a2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  assign stall     = busy1 | busy2;
  assign ready     = idle;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed scenarios plus random traffic, each
// cycle's expected outputs queued by the driver and checked by a monitor.
module tb_register_file_sb;
  import register_file_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NREG = 32;
  localparam int EW = 2 * DW + 4;

  // Handshake: the driver pushes one expected word per cycle just after the
  // rising edge; the monitor pops and compares it at the following falling edge.
  logic          clk;
  logic          rst;
  logic [AW-1:0] a1, a2, a3, iss_addr;
  logic [DW-1:0] wd3;
  logic          we3, iss_valid, clr;
  logic [DW-1:0] rd1, rd2;
  logic          busy1, busy2, stall, ready;
  rf_state_e     dbg_state;

  register_file_sb dut (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .a3(a3), .wd3(wd3), .we3(we3), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy1(busy1), .busy2(busy2), .stall(stall), .clr(clr), .ready(ready),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents, pending flags, next register to sweep.
  logic [DW-1:0] mem [NREG];
  bit            pend [NREG];
  int            sweep_idx;

  logic [EW-1:0] exp_q [$];
  string         tag_q [$];
  string         tag;
  int            n_cmp;
  int            n_err;

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
    sweep_idx = 0;
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (sweep_idx == 0 && we3 && a3 == a) return wd3;
    return mem[a];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a);
    if (a == 0 || sweep_idx != 0) return 1'b0;
    if (we3 && a3 == a) return 1'b0;
    return pend[a];
  endfunction

  function automatic void model_edge();
    if (!rst) begin
      model_reset();
    end else if (sweep_idx != 0) begin
      mem[sweep_idx] = '0;
      sweep_idx = (sweep_idx == NREG - 1) ? 0 : sweep_idx + 1;
    end else if (clr) begin
      for (int i = 0; i < NREG; i++) pend[i] = 1'b0;
      sweep_idx = 1;
    end else begin
      if (we3 && a3 != 0) mem[a3] = wd3;
      if (we3) pend[a3] = 1'b0;
      if (iss_valid && iss_addr != 0) pend[iss_addr] = 1'b1;
    end
  endfunction

  // Driver: called just after a rising edge with the inputs already set.
  task automatic tick();
    logic b1, b2;
    if (!rst) model_reset();
    b1 = model_busy(a1);
    b2 = model_busy(a2);
    exp_q.push_back({model_rd(a1), model_rd(a2), b1, b2, b1 | b2, sweep_idx == 0});
    tag_q.push_back(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we3 = 1'b0; iss_valid = 1'b0; clr = 1'b0;
    a3 = '0; wd3 = '0; iss_addr = '0;
  endtask

  task automatic read_all(input string t);
    idle_inputs();
    tag = t;
    for (int i = 0; i < NREG; i += 2) begin
      a1 = AW'(i); a2 = AW'(i + 1);
      tick();
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, g;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {rd1, rd2, busy1, busy2, stall, ready};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s a1=%0d a2=%0d got rd1=%h rd2=%h b1=%b b2=%b st=%b rdy=%b want rd1=%h rd2=%h b1=%b b2=%b st=%b rdy=%b",
                 t, a1, a2, g[EW-1-:DW], g[DW+3-:DW], g[3], g[2], g[1], g[0],
                 e[EW-1-:DW], e[DW+3-:DW], e[3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0;
    tag = "reset";
    model_reset();
    rst = 1'b0;
    a1 = '0; a2 = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    a1 = 5; a2 = 9;
    tick();
    rst = 1'b1;

    // Write then read on the next cycle, with a non-bypassed read port.
    tag = "wr_r5";
    a3 = 5; wd3 = 32'hDEADBEEF; we3 = 1'b1; a1 = 5; a2 = 6;
    tick();
    idle_inputs(); tag = "rd_r5";
    tick();

    tag = "wr_r0";
    we3 = 1'b1; a3 = 0; wd3 = 32'h1234; a1 = 0; a2 = 0;
    tick();
    idle_inputs(); tick();

    tag = "bypass_r7";
    iss_valid = 1'b1; iss_addr = 7; a1 = 7; a2 = 1;
    tick();
    idle_inputs();
    we3 = 1'b1; a3 = 7; wd3 = 32'hA5A5A5A5; a2 = 7; a1 = 7;
    tick();
    idle_inputs(); tick();

    tag = "issue_r9";
    iss_valid = 1'b1; iss_addr = 9; a1 = 9; a2 = 0;
    tick();
    idle_inputs(); tick();
    tag = "wb_r9";
    we3 = 1'b1; a3 = 9; wd3 = 32'h99; tick();
    idle_inputs(); tick();
    tag = "issue_wb_r9";
    iss_valid = 1'b1; iss_addr = 9; tick();
    idle_inputs();
    we3 = 1'b1; a3 = 9; wd3 = 32'h77; iss_valid = 1'b1; iss_addr = 9; a1 = 10; tick();
    idle_inputs(); a1 = 9; tick();

    // Fill, sweep with an ignored write in the middle, then read back.
    tag = "fill";
    a1 = 3; a2 = 30;
    for (int i = 1; i < NREG; i++) begin
      we3 = 1'b1; a3 = AW'(i); wd3 = $urandom() | 32'h1;
      iss_valid = 1'b1; iss_addr = AW'(NREG - i);
      tick();
    end
    idle_inputs();
    tag = "clr_start";
    clr = 1'b1; we3 = 1'b1; a3 = 4; wd3 = 32'hFFFF; iss_valid = 1'b1; iss_addr = 4;
    a1 = 4; a2 = 3;
    tick();
    idle_inputs();
    tag = "sweep";
    for (int i = 0; i < NREG - 1; i++) begin
      a1 = AW'($urandom_range(0, NREG - 1)); a2 = 3;
      if (i == 10) begin
        we3 = 1'b1; a3 = 3; wd3 = 32'hCAFE; clr = 1'b1; iss_valid = 1'b1; iss_addr = 3;
      end else idle_inputs();
      tick();
    end
    read_all("post_sweep");

    // Reset asserted between edges with the counter at 12.
    tag = "fill2";
    for (int i = 1; i < NREG; i++) begin
      we3 = 1'b1; a3 = AW'(i); wd3 = $urandom() | 32'h2; a1 = AW'(i); a2 = 0;
      tick();
    end
    idle_inputs(); tag = "clr2"; clr = 1'b1; tick();
    clr = 1'b0; tag = "sweep2";
    for (int guard = 0; guard < 64 && sweep_idx != 12; guard++) begin
      a1 = 20; a2 = 12; tick();
    end
    tag = "mid_reset";
    rst = 1'b0; a1 = 20; a2 = 25;
    tick();
    rst = 1'b1;
    read_all("after_reset");

    // Random traffic.
    tag = "random";
    for (int n = 0; n < 600; n++) begin
      we3       = ($urandom_range(0, 1) == 1);
      a3        = AW'($urandom_range(0, NREG - 1));
      wd3       = $urandom();
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, NREG - 1));
      clr       = ($urandom_range(0, 79) == 0);
      a1        = ($urandom_range(0, 3) == 0) ? a3 : AW'($urandom_range(0, NREG - 1));
      a2        = ($urandom_range(0, 3) == 0) ? iss_addr : AW'($urandom_range(0, NREG - 1));
      tick();
    end
    idle_inputs();

    // Bounded drain of the expected queue.
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 Parameter DATA_LENGTH, default 32, SHALL set the register and data-port width in bits.
REQ-002 Parameter ADDR_LENGTH, default 5, SHALL set the address width; register count REGS_QTY = 2**ADDR_LENGTH.
REQ-003 Parameter BYPASS, default 1, SHALL enable write-to-read forwarding when 1 and disable it when 0.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 a1, a2  input  ADDR_LENGTH  read port addresses.
REQ-007 rd1, rd2  output  DATA_LENGTH  read data for a1, a2.
REQ-008 a3  input  ADDR_LENGTH  write-back address.
REQ-009 wd3  input  DATA_LENGTH  write-back data.
REQ-010 we3  input  1  write-back enable; also clears the scoreboard bit of a3.
REQ-011 iss_valid  input  1  an instruction issues and will write iss_addr later.
REQ-012 iss_addr  input  ADDR_LENGTH  destination register of the issuing instruction.
REQ-013 busy1, busy2  output  1  pending write outstanding on a1, a2.
REQ-014 stall  output  1  busy1 OR busy2.
REQ-015 clr  input  1  single-cycle request to start a register-clear sweep.
REQ-016 ready  output  1  high in IDLE, low during a clear sweep.

Function
REQ-017 Register 0 SHALL always read as zero; writes, issues and busy marking for address 0 SHALL be ignored.
REQ-018 Reads SHALL be combinational from register contents (zero latency).
REQ-019 With BYPASS=1, when we3=1, a3=ax and ax!=0, rdx SHALL equal wd3 in the same cycle; with BYPASS=0, the written value SHALL appear the cycle after the edge.
REQ-020 A write with we3=1 and a3!=0 in IDLE SHALL update the register at the next rising edge (1-cycle write latency).
REQ-021 Scoreboard: one busy bit per register; iss_valid=1 with iss_addr!=0 in IDLE SHALL set busy[iss_addr] at the next edge.
REQ-022 we3=1 in IDLE SHALL clear busy[a3] at the next edge.
REQ-023 Simultaneous issue and write-back to the same address SHALL leave the busy bit set (issue wins).
REQ-024 busyx SHALL be busy[ax], except 0 when ax=0, and with BYPASS=1 SHALL be 0 when we3=1 and a3=ax.
REQ-025 FSM states: IDLE, CLEAR.
REQ-026 IDLE->CLEAR on clr=1.
REQ-027 Entering CLEAR SHALL clear all busy bits and load the sweep counter with 1.
REQ-028 In CLEAR, one register per cycle SHALL be written with zero at the counter address, then the counter increments.
REQ-029 When the counter reaches REGS_QTY-1 and that register is cleared, the FSM SHALL return to IDLE, giving a sweep of REGS_QTY-1 cycles.
REQ-030 In CLEAR, we3, iss_valid and clr SHALL be ignored; reads SHALL return current contents without bypass; busy1, busy2 and stall SHALL be 0; ready SHALL be 0.
REQ-031 clr in the same cycle as we3 or iss_valid in IDLE SHALL take precedence: the write and the issue are discarded.

Reset
REQ-032 rst=0 SHALL, without waiting for clk, clear all registers, all busy bits and the sweep counter, and force state IDLE; ready SHALL read 1 and busy1, busy2 and stall 0.
REQ-033 Assertion of rst mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE.

Structure
REQ-034 The FSM state encoding and the default parameter values SHALL reside in a shared package, register_file_pkg.
REQ-035 The scoreboard SHALL be a separate sub-module, rf_scoreboard, holding the busy bits, their set/clear logic and the busy1/busy2 lookups.

Verification
REQ-036 Reset, then write 0xDEADBEEF to r5, then read a1=5 on the next cycle -> rd1=0xDEADBEEF.
REQ-037 we3=1, a3=0, wd3=0x1234 -> rd1 with a1=0 stays 0x00000000.
REQ-038 BYPASS=1: we3=1, a3=7, wd3=0xA5A5A5A5 with a2=7 in the same cycle -> rd2=0xA5A5A5A5 and busy2=0 that cycle.
REQ-039 Issue r9 -> busy1=1 and stall=1 with a1=9; write-back of r9 -> busy1=0 the next cycle; issue and write-back of r9 in the same cycle -> busy1 stays 1.
REQ-040 Fill r1..r31 with nonzero data, pulse clr -> ready=0 for 31 cycles; afterward all reads return 0 and ready=1; a we3 during the sweep is ignored.
REQ-041 rst=0 asserted mid-sweep at counter=12 -> immediate IDLE, ready=1, all registers read 0.
